// File: rtl/main_memory_ctrl_pkg.sv
// Shared codes for the main-memory controller and its cache clients.
// Optional MEM_BOUNDS_CHECK_EN enables out-of-range beat detection.
package main_memory_ctrl_pkg;

    localparam logic [1:0] MEM_NOP        = 2'd0;
    localparam logic [1:0] MEM_READ       = 2'd1;
    localparam logic [1:0] MEM_READ_BURST = 2'd2;
    localparam logic [1:0] MEM_WRITE      = 2'd3;

    localparam logic [1:0] MEM_RESTING      = 2'd0;
    localparam logic [1:0] MEM_DATA_WORKING = 2'd1;
    localparam logic [1:0] MEM_INST_WORKING = 2'd2;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHECK = 1'b1;
`else
    localparam bit BOUNDS_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_D_BUSY,
        ST_I_BUSY
    } state_e;

    function automatic logic [1:0] status_of(input state_e s);
        logic [1:0] st;
        st = MEM_RESTING;
        case (s)
            ST_D_BUSY: st = MEM_DATA_WORKING;
            ST_I_BUSY: st = MEM_INST_WORKING;
            default:   st = MEM_RESTING;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/main_memory_ctrl_ram.sv
// Single-port word RAM with write enable and a registered read port.
// Reset clears only the read register; contents are preserved.
module main_memory_ctrl_ram #(
    parameter int AW = 15,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          re,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [0:(2**AW)-1];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[addr];
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
        if (!rstn) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/main_memory_ctrl.sv
// Main-memory controller: d/i arbiter, burst FSM, shared backing RAM.
// Define MEM_BOUNDS_CHECK_EN to flag and suppress out-of-range beats.
module main_memory_ctrl
    import main_memory_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [1:0]                d_mem_vis_signal,
    input  logic [ADDR_WIDTH-1:0]     d_mem_vis_addr,
    input  logic [LEN-1:0]            d_mem_writen_data,
    input  logic [ENTRY_INDEX_SIZE:0] d_write_length,
    output logic [LEN-1:0]            d_mem_data,
    input  logic [1:0]                i_mem_vis_signal,
    input  logic [ADDR_WIDTH-1:0]     i_mem_vis_addr,
    output logic [LEN-1:0]            i_mem_data,
    output logic [1:0]                mem_status,
    output logic                      mem_err
);

    localparam int WA = ADDR_WIDTH - 2;
    localparam int CW = ENTRY_INDEX_SIZE + 1;
    localparam logic [CW-1:0] VEC = CW'(VECTOR_SIZE);

    state_e        state_q, state_d;
    logic [1:0]    op_q, op_d, cur_op;
    logic [CW-1:0] cnt_q, cnt_d, beat, eff_len;
    logic          d_own_q, d_own_d, i_own_q, i_own_d;
    logic          oob_q, oob_d, err_q, err_d;
    logic [1:0]    status_q, status_d;
    logic [LEN-1:0] d_keep_q, d_keep_d, i_keep_q, i_keep_d;
    logic [LEN-1:0] ram_rdata, rd_word;
    logic [WA:0]   d_sum;
    logic [WA-1:0] ram_addr;
    logic          beat_oob, d_beat, ram_re, ram_we;
    logic          unused_lsbs;

    assign unused_lsbs = ^{d_mem_vis_addr[1:0], i_mem_vis_addr[1:0]};

    assign beat    = (state_q == ST_IDLE) ? '0 : cnt_q;
    assign cur_op  = (state_q == ST_IDLE) ? d_mem_vis_signal : op_q;
    assign eff_len = (d_write_length == '0) ? VEC : d_write_length;
    // Carry out of base+beat marks a beat past the top of memory
    assign d_sum    = {1'b0, d_mem_vis_addr[ADDR_WIDTH-1:2]} + (WA+1)'(beat);
    assign beat_oob = d_sum[WA] & BOUNDS_CHECK;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        d_own_d  = d_own_q;
        i_own_d  = i_own_q;
        oob_d    = oob_q;
        err_d    = err_q;
        d_beat   = 1'b0;
        ram_re   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = d_sum[WA-1:0];
        case (state_q)
            ST_IDLE: begin
                if (d_mem_vis_signal != MEM_NOP) begin
                    state_d = ST_D_BUSY;
                    op_d    = d_mem_vis_signal;
                    d_beat  = 1'b1;
                end else if (i_mem_vis_signal == MEM_READ) begin
                    state_d  = ST_I_BUSY;
                    ram_re   = 1'b1;
                    ram_addr = i_mem_vis_addr[ADDR_WIDTH-1:2];
                    d_own_d  = 1'b0;
                    i_own_d  = 1'b1;
                    oob_d    = 1'b0;
                end
            end
            ST_D_BUSY: begin
                if (op_q == MEM_READ || cnt_q == VEC ||
                    d_mem_vis_signal != op_q)
                    state_d = ST_IDLE;
                else
                    d_beat = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (d_beat) begin
            cnt_d = beat + CW'(1);
            err_d = err_q | beat_oob;
            if (cur_op == MEM_WRITE) begin
                ram_we = (beat < eff_len) && !beat_oob;
            end else begin
                ram_re  = 1'b1;
                d_own_d = 1'b1;
                i_own_d = 1'b0;
                oob_d   = beat_oob;
            end
        end
        status_d = status_of(state_d);
    end

    assign rd_word = oob_q ? '0 : ram_rdata;

    // RAM output belongs to whichever side read last; the other side holds
    always_comb begin
        d_keep_d = d_own_q ? rd_word : d_keep_q;
        i_keep_d = i_own_q ? rd_word : i_keep_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            op_q     <= MEM_NOP;
            cnt_q    <= '0;
            d_own_q  <= 1'b0;
            i_own_q  <= 1'b0;
            oob_q    <= 1'b0;
            err_q    <= 1'b0;
            status_q <= MEM_RESTING;
            d_keep_q <= '0;
            i_keep_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            d_own_q  <= d_own_d;
            i_own_q  <= i_own_d;
            oob_q    <= oob_d;
            err_q    <= err_d;
            status_q <= status_d;
            d_keep_q <= d_keep_d;
            i_keep_q <= i_keep_d;
        end
    end

    main_memory_ctrl_ram #(
        .AW (WA),
        .DW (LEN)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .re    (ram_re),
        .we    (ram_we & rstn),
        .addr  (ram_addr),
        .wdata (d_mem_writen_data),
        .rdata (ram_rdata)
    );

    assign d_mem_data = d_own_q ? rd_word : d_keep_q;
    assign i_mem_data = i_own_q ? rd_word : i_keep_q;
    assign mem_status = status_q;
    assign mem_err    = err_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Randomised bench for main_memory_ctrl against a word-array memory model.
// Honours MEM_BOUNDS_CHECK_EN for the wrap/bounds expectations.
module tb_main_memory_ctrl;
    import main_memory_ctrl_pkg::*;

    localparam int DEPTH = 32768;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  d_sig, i_sig;
    logic [16:0] d_addr, i_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_len;
    logic [31:0] d_data, i_data;
    logic [1:0]  status;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [DEPTH];
    logic        err_exp;
    logic [31:0] last_d, last_i;

    always #5 clk = ~clk;

    main_memory_ctrl dut (
        .clk               (clk),
        .rstn              (rstn),
        .d_mem_vis_signal  (d_sig),
        .d_mem_vis_addr    (d_addr),
        .d_mem_writen_data (d_wdata),
        .d_write_length    (d_len),
        .d_mem_data        (d_data),
        .i_mem_vis_signal  (i_sig),
        .i_mem_vis_addr    (i_addr),
        .i_mem_data        (i_data),
        .mem_status        (status),
        .mem_err           (err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_rd(input int w, input int k);
        int idx;
        idx = w + k;
        if (idx >= DEPTH) begin
`ifdef MEM_BOUNDS_CHECK_EN
            err_exp = 1'b1;
            return 32'h0;
`else
            idx -= DEPTH;
`endif
        end
        return mdl[idx];
    endfunction

    function automatic void model_wr(input int w, input int k,
                                     input logic [31:0] v);
        int idx;
        idx = w + k;
        if (idx >= DEPTH) begin
`ifdef MEM_BOUNDS_CHECK_EN
            err_exp = 1'b1;
            return;
`else
            idx -= DEPTH;
`endif
        end
        mdl[idx] = v;
    endfunction

    task automatic d_write(input logic [16:0] a, input int nb, input int len,
                           input logic [31:0] first, input bit incr);
        int w, eff;
        logic [31:0] v;
        w = int'(a >> 2);
        eff = (len == 0) ? 8 : len;
        for (int k = 0; k < nb; k++) begin
            v = incr ? first + 32'(k) : $urandom;
            d_sig = MEM_WRITE; d_addr = a; d_wdata = v; d_len = 4'(len);
            step();
            check("wr_status", 32'(status), 32'(MEM_DATA_WORKING));
            if (k < eff) model_wr(w, k, v);
        end
        d_sig = MEM_NOP;
        step();
        check("wr_rest", 32'(status), 32'(MEM_RESTING));
        check("wr_dhold", d_data, last_d);
        check("wr_err", 32'(err), 32'(err_exp));
    endtask

    task automatic d_read(input logic [16:0] a);
        logic [31:0] e;
        e = model_rd(int'(a >> 2), 0);
        d_sig = MEM_READ; d_addr = a;
        step();
        check("rd_data", d_data, e);
        check("rd_status", 32'(status), 32'(MEM_DATA_WORKING));
        d_sig = MEM_NOP;
        step();
        check("rd_rest", 32'(status), 32'(MEM_RESTING));
        check("rd_hold", d_data, e);
        last_d = e;
    endtask

    task automatic d_burst(input logic [16:0] a, input int n, input bit hold);
        logic [31:0] e;
        e = last_d;
        for (int k = 0; k < n; k++) begin
            d_sig = MEM_READ_BURST; d_addr = a;
            step();
            e = model_rd(int'(a >> 2), k);
            check($sformatf("burst_b%0d", k), d_data, e);
            check("burst_status", 32'(status), 32'(MEM_DATA_WORKING));
        end
        if (!hold) d_sig = MEM_NOP;
        step();
        d_sig = MEM_NOP;
        check("burst_rest", 32'(status), 32'(MEM_RESTING));
        check("burst_hold", d_data, e);
        check("burst_err", 32'(err), 32'(err_exp));
        last_d = e;
    endtask

    task automatic i_read(input logic [16:0] a);
        logic [31:0] e;
        e = mdl[int'(a >> 2)];
        i_sig = MEM_READ; i_addr = a;
        step();
        check("ird_data", i_data, e);
        check("ird_status", 32'(status), 32'(MEM_INST_WORKING));
        check("ird_dhold", d_data, last_d);
        i_sig = MEM_NOP;
        step();
        check("ird_rest", 32'(status), 32'(MEM_RESTING));
        last_i = e;
    endtask

    initial begin
        logic [31:0] ea, eb;
        int op, w;
        logic [16:0] a;
        rstn = 1'b0; d_sig = MEM_NOP; i_sig = MEM_NOP;
        d_addr = '0; i_addr = '0; d_wdata = '0; d_len = '0;
        err_exp = 1'b0; last_d = '0; last_i = '0;
        repeat (3) step();
        check("rst_status", 32'(status), 32'(MEM_RESTING));
        check("rst_d", d_data, 32'h0);
        check("rst_i", i_data, 32'h0);
        check("rst_err", 32'(err), 32'(err_exp));
        rstn = 1'b1;
        step();

        for (int b = 0; b < 32; b++) d_write(17'(b * 32), 8, 8, 0, 1'b0);
        d_write(17'h1FFE0, 8, 0, 0, 1'b0);

        d_write(17'h100, 1, 1, 32'h40, 1'b1);
        d_read(17'h100);
        check("scalar_const", d_data, 32'h40);

        d_write(17'h200, 8, 8, 32'h10, 1'b1);
        d_burst(17'h200, 8, 1'b1);
        check("burst_last_const", d_data, 32'h17);

        d_write(17'h300, 8, 3, 32'hA0, 1'b1);
        d_burst(17'h300, 8, 1'b0);

        ea = model_rd(16'h0108 >> 2, 0);
        eb = mdl[16'h0040 >> 2];
        d_sig = MEM_READ; d_addr = 17'h108;
        i_sig = MEM_READ; i_addr = 17'h040;
        step();
        check("arb_d", d_data, ea);
        check("arb_status_d", 32'(status), 32'(MEM_DATA_WORKING));
        check("arb_i_wait", i_data, last_i);
        d_sig = MEM_NOP;
        step();
        check("arb_gap", 32'(status), 32'(MEM_RESTING));
        check("arb_i_wait2", i_data, last_i);
        step();
        check("arb_i", i_data, eb);
        check("arb_status_i", 32'(status), 32'(MEM_INST_WORKING));
        check("arb_dhold", d_data, ea);
        i_sig = MEM_NOP;
        step();
        check("arb_rest", 32'(status), 32'(MEM_RESTING));
        last_d = ea; last_i = eb;

        d_burst(17'h1FFFC, 2, 1'b0);

        for (int k = 0; k < 4; k++) begin
            d_sig = MEM_WRITE; d_addr = 17'h380;
            d_wdata = 32'hC0 + 32'(k); d_len = 4'd8;
            step();
            model_wr(17'h380 >> 2, k, d_wdata);
        end
        d_wdata = 32'hC4; rstn = 1'b0;
        step();
        err_exp = 1'b0; last_d = '0; last_i = '0;
        check("mid_rst_status", 32'(status), 32'(MEM_RESTING));
        check("mid_rst_d", d_data, 32'h0);
        check("mid_rst_i", i_data, 32'h0);
        check("mid_rst_err", 32'(err), 32'(err_exp));
        rstn = 1'b1; d_sig = MEM_NOP;
        step();
        d_burst(17'h380, 8, 1'b0);

        for (int t = 0; t < 60; t++) begin
            op = $urandom_range(0, 3);
            w = $urandom_range(0, 247);
            a = 17'(w * 4 + $urandom_range(0, 3));
            case (op)
                0: d_read(a);
                1: d_burst(a, $urandom_range(1, 8), 1'b0);
                2: d_write(a, $urandom_range(1, 8), $urandom_range(0, 8),
                           0, 1'b0);
                default: i_read(a);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
